mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: the multi-cycle CPU (fetch and load/store) and a debug/loader port.
- Serialises accesses, inserts the memory's read latency and returns a one-cycle ack.
- The CPU control FSM holds its memory state until ack, so slow memory and loader traffic stall the CPU instead of corrupting it.
- Sits between the CPU datapath's memory interface and the memory macro.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata valid; legal range 1..7
- CPU_PRIO, 1, 1 = CPU always wins contention; 0 = round-robin

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  CPU write enable (1 = store)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU store data
- cpu_rdata  out  DW  registered CPU read data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same as the cpu_* ports, for the debug/loader requester
- mem_en  out  1  memory access strobe, exactly one cycle per transaction
- mem_we  out  1  memory write enable, valid with mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state=IDLE; mem_en=0; mem_we=0; cpu_ack=dbg_ack=0; cpu_rdata=dbg_rdata=0; last_owner=DBG; wait counter=0.
  - An in-flight transaction is dropped with no ack.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select the owner and latch owner, we, addr and wdata from that requester. Next state is ISSUE.
  - With no req, remain in IDLE.
- Arbitration, CPU_PRIO=1: the CPU wins whenever cpu_req=1.
- Arbitration, CPU_PRIO=0: a lone requester wins. On a tie, the requester that is not last_owner wins. last_owner updates at grant. Since it resets to DBG, the CPU wins the first tie.
- ISSUE:
  - mem_en=1; mem_we, mem_addr and mem_wdata driven from the latched values.
  - Write: next state RESP.
  - Read: load counter=MEM_LAT-1; next state WAIT.
- WAIT (reads only):
  - mem_en=0. The counter decrements each cycle.
  - In the cycle where the counter is 0, mem_rdata is captured into the owner's rdata register and the next state is RESP.
  - With MEM_LAT=1, the FSM spends exactly one cycle in WAIT.
- RESP: owner's ack=1 for exactly one cycle; next state IDLE.
- Latency, with req first seen high in IDLE at cycle c:
  - Write: mem_en at c+1, ack at c+2.
  - Read: mem_en at c+1, ack at c+MEM_LAT+2, with rdata valid in the ack cycle.
- Requester rules:
  - req, we, addr and wdata are latched at grant; later changes to them are ignored for the current transaction.
  - A requester keeping req high through the ack cycle is granted again in the following IDLE cycle, subject to arbitration.
  - Dropping req after grant does not cancel the transaction; the ack is still issued.
- rdata registers hold their value until the next read completes for the same requester. Writes never modify rdata.
- The loser of arbitration keeps req high and is considered again in the next IDLE. In round-robin mode it wins that IDLE if the other requester is also requesting.
- mem_addr and mem_wdata hold their latched values outside ISSUE; they are don't-care when mem_en=0.
- busy is combinational from state.
- Out-of-range MEM_LAT (0 or >7) is a configuration error and must be caught by an elaboration-time check.

Test Plan:
- Reset then single CPU read, MEM_LAT=1, addr=0x10, memory returns 0xDEADBEEF -> mem_en at c+1 with mem_we=0; cpu_ack at c+3; cpu_rdata=0xDEADBEEF; dbg_ack never asserted.
- CPU write addr=0x20, data=0x12345678 -> mem_en=1 and mem_we=1 at c+1 with that addr/data; cpu_ack at c+2; a subsequent CPU read of 0x20 returns 0x12345678.
- MEM_LAT=3, dbg read -> dbg_ack exactly at c+5, exactly one cycle wide; exactly one mem_en pulse.
- CPU_PRIO=0, both req held high continuously for 4 transactions -> grant order CPU, DBG, CPU, DBG; an IDLE cycle between each RESP and the next ISSUE.
- CPU_PRIO=1, both req held high -> CPU served every transaction; dbg_ack stays 0 while cpu_req is high; DBG is served in the first IDLE with cpu_req=0.
- rst asserted in WAIT of a read (MEM_LAT=4) -> next cycle state IDLE, mem_en=0, no ack ever issued for that read, rdata=0; a new request after reset completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between the multi-cycle CPU and a
// debug/loader port. One transaction is in flight at a time: the winner's
// request is latched at grant, issued to the memory for exactly one cycle,
// the read latency is waited out, and a one-cycle ack is returned to the
// owner. Requesters hold req until ack, so a slow memory or loader traffic
// simply stalls the CPU rather than corrupting its access.

module mem_port_arbiter #(
  parameter int AW       = 32,  // address width
  parameter int DW       = 32,  // data width
  parameter int MEM_LAT  = 1,   // mem_en cycle to mem_rdata valid, 1..7
  parameter int CPU_PRIO = 1    // 1: CPU always wins, 0: round-robin
) (
  input  logic          clk,
  input  logic          rst,

  // CPU requester
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,

  // Debug / loader requester
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,

  // Memory macro side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  // ---------------------------------------------------------------------------
  // Configuration check: the wait counter is three bits wide and a latency of
  // zero would have no cycle in which to capture read data.
  // ---------------------------------------------------------------------------
  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT=%0d is outside the legal range 1..7", MEM_LAT);
  end

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // waiting for a request
    S_ISSUE = 2'd1,  // single-cycle memory strobe
    S_WAIT  = 2'd2,  // read latency countdown, data captured on the last cycle
    S_RESP  = 2'd3   // one-cycle ack to the owner
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam int            CW       = 3;
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q,      state_d;
  owner_e          owner_q,      owner_d;       // requester of the current transaction
  owner_e          last_owner_q, last_owner_d;  // most recent grant, for round-robin
  logic            we_q,         we_d;
  logic [AW-1:0]   addr_q,       addr_d;
  logic [DW-1:0]   wdata_q,      wdata_d;
  logic [CW-1:0]   cnt_q,        cnt_d;
  logic [DW-1:0]   cpu_rdata_q,  cpu_rdata_d;
  logic [DW-1:0]   dbg_rdata_q,  dbg_rdata_d;

  logic            any_req;
  logic            grant_dbg;

  assign any_req = cpu_req | dbg_req;

  // Arbitration: decide which requester would win if a grant happens now.
  always_comb begin
    grant_dbg = 1'b0;
    if (CPU_PRIO != 0) begin
      grant_dbg = !cpu_req;
    end else if (cpu_req && dbg_req) begin
      // On a tie the requester that did not win last time takes its turn.
      grant_dbg = (last_owner_q == OWN_CPU);
    end else begin
      grant_dbg = !cpu_req;
    end
  end

  // Next-state and datapath-register update for the transaction FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          // Everything the transaction needs is frozen here; the requester may
          // change or drop its inputs afterwards without affecting it.
          state_d = S_ISSUE;
          if (grant_dbg) begin
            owner_d      = OWN_DBG;
            last_owner_d = OWN_DBG;
            we_d         = dbg_we;
            addr_d       = dbg_addr;
            wdata_d      = dbg_wdata;
          end else begin
            owner_d      = OWN_CPU;
            last_owner_d = OWN_CPU;
            we_d         = cpu_we;
            addr_d       = cpu_addr;
            wdata_d      = cpu_wdata;
          end
        end
      end

      S_ISSUE: begin
        if (we_q) begin
          // Writes complete at the memory edge; nothing to wait for.
          state_d = S_RESP;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          // mem_rdata is valid in exactly this cycle.
          if (owner_q == OWN_DBG) begin
            dbg_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; an in-flight transaction is dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DBG;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: strobes and acks decode directly from state, so each is high for
  // exactly the one cycle spent in ISSUE or RESP and low out of reset.
  // ---------------------------------------------------------------------------
  assign mem_en    = (state_q == S_ISSUE);
  assign mem_we    = (state_q == S_ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign cpu_ack   = (state_q == S_RESP) && (owner_q == OWN_CPU);
  assign dbg_ack   = (state_q == S_RESP) && (owner_q == OWN_DBG);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Three instances cover the configurations of
// interest: inst 0 (MEM_LAT=1, CPU priority), inst 1 (MEM_LAT=3, round-robin),
// inst 2 (MEM_LAT=4, CPU priority). Each has its own behavioural memory with
// the matching read latency. Inputs are driven and outputs sampled on the
// falling clock edge.

module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [N];
  logic          cpu_req   [N];
  logic          cpu_we    [N];
  logic [AW-1:0] cpu_addr  [N];
  logic [DW-1:0] cpu_wdata [N];
  logic [DW-1:0] cpu_rdata [N];
  logic          cpu_ack   [N];
  logic          dbg_req   [N];
  logic          dbg_we    [N];
  logic [AW-1:0] dbg_addr  [N];
  logic [DW-1:0] dbg_wdata [N];
  logic [DW-1:0] dbg_rdata [N];
  logic          dbg_ack   [N];
  logic          mem_en    [N];
  logic          mem_we    [N];
  logic [AW-1:0] mem_addr  [N];
  logic [DW-1:0] mem_wdata [N];
  logic [DW-1:0] mem_rdata [N];
  logic          busy      [N];

  int compared   = 0;
  int mismatched = 0;

  // Initial memory image; address 0x10 holds the well-known read pattern.
  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {24'hA5C300, a} ^ {a, 24'h000000};
  endfunction

  function automatic int lat_of(input int inst);
    return (inst == 0) ? 1 : (inst == 1) ? 3 : 4;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT  = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int PRIO = (g == 1) ? 0 : 1;

    logic [DW-1:0] mem  [256];
    logic [DW-1:0] pipe [LAT];

    initial for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));

    // Memory model: reads emerge LAT cycles after the mem_en cycle; any other
    // cycle shows a poison value so a mistimed capture is visible.
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g][7:0]] : 32'hBAD0BAD0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[LAT-1];

    mem_port_arbiter #(
      .AW(AW), .DW(DW), .MEM_LAT(LAT), .CPU_PRIO(PRIO)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .cpu_req  (cpu_req[g]),
      .cpu_we   (cpu_we[g]),
      .cpu_addr (cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]),
      .cpu_rdata(cpu_rdata[g]),
      .cpu_ack  (cpu_ack[g]),
      .dbg_req  (dbg_req[g]),
      .dbg_we   (dbg_we[g]),
      .dbg_addr (dbg_addr[g]),
      .dbg_wdata(dbg_wdata[g]),
      .dbg_rdata(dbg_rdata[g]),
      .dbg_ack  (dbg_ack[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g])
    );
  end

  // Scoreboard of expected completions, pushed at drive time.
  typedef struct {
    bit            dbg;
    bit            we;
    logic [DW-1:0] data;
    int            lat;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] shadow [N][256];

  task automatic drive(input int inst, input bit dbg, input bit req, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (dbg) begin
      dbg_req[inst] = req; dbg_we[inst] = we; dbg_addr[inst] = a; dbg_wdata[inst] = wd;
    end else begin
      cpu_req[inst] = req; cpu_we[inst] = we; cpu_addr[inst] = a; cpu_wdata[inst] = wd;
    end
  endtask

  function automatic exp_t make_exp(input int inst, input bit dbg, input bit we,
                                    input logic [7:0] a, input logic [DW-1:0] wd);
    exp_t e;
    e.dbg  = dbg;
    e.we   = we;
    e.data = we ? wd : shadow[inst][a];
    e.lat  = lat_of(inst);
    return e;
  endfunction

  // One isolated transaction starting from IDLE at the current falling edge.
  task automatic do_access(input int inst, input bit dbg, input bit we,
                           input logic [7:0] a, input logic [DW-1:0] wd, input string tag);
    exp_t          e;
    int            waited;
    int            en_cnt;
    bit            acked;
    bit            other_ack;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] got;
    eaddr = {24'h0, a};
    sb.push_back(make_exp(inst, dbg, we, a, wd));
    if (we) shadow[inst][a] = wd;
    drive(inst, dbg, 1'b1, we, eaddr, wd);

    @(negedge clk);  // c+1: ISSUE
    compared++;
    if (mem_en[inst] !== 1'b1 || mem_we[inst] !== we || mem_addr[inst] !== eaddr ||
        (we && mem_wdata[inst] !== wd)) begin
      mismatched++;
      $display("FAIL %s_issue: mem_en=%0b mem_we=%0b addr=%h wdata=%h, required en=1 we=%0b addr=%h wdata=%h",
               tag, mem_en[inst], mem_we[inst], mem_addr[inst], mem_wdata[inst], we, eaddr, wd);
    end
    // Changing inputs after grant must not affect the transaction.
    drive(inst, dbg, 1'b1, ~we, ~eaddr, ~wd);

    en_cnt = 1; waited = 1; acked = 1'b0; other_ack = 1'b0;
    while (!acked && waited < 20) begin
      @(negedge clk);
      waited++;
      if (mem_en[inst]) en_cnt++;
      if (dbg ? cpu_ack[inst] : dbg_ack[inst]) other_ack = 1'b1;
      if (dbg ? dbg_ack[inst] : cpu_ack[inst]) acked = 1'b1;
    end
    e = sb.pop_front();

    compared++;
    if (!acked || waited != (e.we ? 2 : e.lat + 2)) begin
      mismatched++;
      $display("FAIL %s_latency: acked=%0b at c+%0d, required ack at c+%0d",
               tag, acked, waited, e.we ? 2 : e.lat + 2);
    end
    if (!e.we) begin
      got = dbg ? dbg_rdata[inst] : cpu_rdata[inst];
      compared++;
      if (got !== e.data) begin
        mismatched++;
        $display("FAIL %s_rdata: got %h, required %h", tag, got, e.data);
      end
    end
    compared++;
    if (en_cnt != 1 || other_ack) begin
      mismatched++;
      $display("FAIL %s_single: mem_en pulses=%0d other_ack=%0b, required 1 and 0", tag, en_cnt, other_ack);
    end

    drive(inst, dbg, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    compared++;
    if (cpu_ack[inst] !== 1'b0 || dbg_ack[inst] !== 1'b0 || busy[inst] !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_ack_width: cpu_ack=%0b dbg_ack=%0b busy=%0b after ack, required 0 0 0",
               tag, cpu_ack[inst], dbg_ack[inst], busy[inst]);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < N; i++) begin
      compared++;
      if (busy[i] !== 1'b0 || mem_en[i] !== 1'b0 || mem_we[i] !== 1'b0 || cpu_ack[i] !== 1'b0 ||
          dbg_ack[i] !== 1'b0 || cpu_rdata[i] !== '0 || dbg_rdata[i] !== '0) begin
        mismatched++;
        $display("FAIL reset_%0d: busy=%0b en=%0b we=%0b acks=%0b%0b rdata=%h/%h, required all zero",
                 i, busy[i], mem_en[i], mem_we[i], cpu_ack[i], dbg_ack[i], cpu_rdata[i], dbg_rdata[i]);
      end
    end
  endtask

  task automatic test_cpu_read;
    do_access(0, 1'b0, 1'b0, 8'h10, '0, "cpu_read");
  endtask

  task automatic test_cpu_write;
    do_access(0, 1'b0, 1'b1, 8'h20, 32'h12345678, "cpu_write");
    compared++;
    if (cpu_rdata[0] !== 32'hDEADBEEF) begin
      mismatched++;
      $display("FAIL write_keeps_rdata: cpu_rdata=%h, required DEADBEEF", cpu_rdata[0]);
    end
    do_access(0, 1'b0, 1'b0, 8'h20, '0, "cpu_readback");
  endtask

  task automatic test_dbg_lat3;
    do_access(1, 1'b1, 1'b0, 8'h25, '0, "dbg_lat3");
    do_access(1, 1'b1, 1'b1, 8'h26, 32'hCAFEF00D, "dbg_write");
    do_access(1, 1'b1, 1'b0, 8'h26, '0, "dbg_readback");
  endtask

  task automatic test_round_robin;
    exp_t e;
    int   acks = 0;
    int   t = 0;
    bit   prev_ack = 1'b0;
    bit   ca, da;
    logic [DW-1:0] got;
    for (int k = 0; k < 4; k++) sb.push_back(make_exp(1, k[0], 1'b0, k[0] ? 8'h32 : 8'h31, '0));
    drive(1, 1'b0, 1'b1, 1'b0, 32'h31, '0);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h32, '0);
    while (acks < 4 && t < 200) begin
      @(negedge clk);
      t++;
      if (prev_ack) begin
        compared++;
        if (busy[1] !== 1'b0) begin
          mismatched++;
          $display("FAIL rr_idle_gap: busy=%0b after ack %0d, required 0", busy[1], acks);
        end
      end
      ca = cpu_ack[1]; da = dbg_ack[1];
      prev_ack = ca | da;
      if (prev_ack) begin
        e = sb.pop_front();
        acks++;
        got = da ? dbg_rdata[1] : cpu_rdata[1];
        compared++;
        if ((ca && da) || da !== e.dbg || got !== e.data) begin
          mismatched++;
          $display("FAIL rr_order: grant %0d cpu_ack=%0b dbg_ack=%0b data=%h, required dbg=%0b data=%h",
                   acks, ca, da, got, e.dbg, e.data);
        end
        if (acks == 4) begin
          drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
          drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    compared++;
    if (acks != 4) begin
      mismatched++;
      $display("FAIL rr_timeout: %0d acks seen, required 4", acks);
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
      sb.delete();
    end
    @(negedge clk);
    compared++;
    if (busy[1] !== 1'b0) begin
      mismatched++;
      $display("FAIL rr_final_idle: busy=%0b, required 0", busy[1]);
    end
  endtask

  task automatic test_cpu_priority;
    exp_t e;
    int   cpu_acks = 0;
    int   t = 0;
    int   waited = 0;
    bit   acked = 1'b0;
    for (int k = 0; k < 3; k++) sb.push_back(make_exp(0, 1'b0, 1'b0, 8'h40, '0));
    drive(0, 1'b0, 1'b1, 1'b0, 32'h40, '0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h41, '0);
    while (cpu_acks < 3 && t < 100) begin
      @(negedge clk);
      t++;
      compared++;
      if (dbg_ack[0] !== 1'b0) begin
        mismatched++;
        $display("FAIL prio_dbg_starved: dbg_ack=%0b while cpu_req high, required 0", dbg_ack[0]);
      end
      if (cpu_ack[0]) begin
        e = sb.pop_front();
        cpu_acks++;
        compared++;
        if (cpu_rdata[0] !== e.data) begin
          mismatched++;
          $display("FAIL prio_cpu_rdata: got %h, required %h", cpu_rdata[0], e.data);
        end
        if (cpu_acks == 3) drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      end
    end
    compared++;
    if (cpu_acks != 3) begin
      mismatched++;
      $display("FAIL prio_timeout: %0d cpu acks, required 3", cpu_acks);
      sb.delete();
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    end
    // First IDLE with cpu_req low is the next cycle; DBG is granted there.
    sb.push_back(make_exp(0, 1'b1, 1'b0, 8'h41, '0));
    while (!acked && waited < 20) begin
      @(negedge clk);
      waited++;
      if (dbg_ack[0]) acked = 1'b1;
    end
    e = sb.pop_front();
    compared++;
    if (!acked || waited != e.lat + 3 || dbg_rdata[0] !== e.data) begin
      mismatched++;
      $display("FAIL prio_dbg_after: acked=%0b at +%0d data=%h, required ack at +%0d data=%h",
               acked, waited, dbg_rdata[0], e.lat + 3, e.data);
    end
    drive(0, 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait;
    bit ack_seen = 1'b0;
    do_access(2, 1'b0, 1'b0, 8'h10, '0, "pre_reset_read");
    drive(2, 1'b0, 1'b1, 1'b0, 32'h50, '0);
    @(negedge clk);  // ISSUE
    @(negedge clk);  // WAIT, counter 3
    compared++;
    if (busy[2] !== 1'b1 || mem_en[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_setup: busy=%0b mem_en=%0b, required 1 0", busy[2], mem_en[2]);
    end
    rst[2] = 1'b1;
    drive(2, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    compared++;
    if (busy[2] !== 1'b0 || mem_en[2] !== 1'b0 || cpu_rdata[2] !== '0 || cpu_ack[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_in_wait: busy=%0b mem_en=%0b rdata=%h ack=%0b, required 0 0 0 0",
               busy[2], mem_en[2], cpu_rdata[2], cpu_ack[2]);
    end
    rst[2] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cpu_ack[2] || dbg_ack[2] || busy[2]) ack_seen = 1'b1;
    end
    compared++;
    if (ack_seen) begin
      mismatched++;
      $display("FAIL rst_no_ack: activity seen after reset, required none");
    end
    do_access(2, 1'b0, 1'b0, 8'h51, '0, "post_reset_read");
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      drive(i, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(i, 1'b1, 1'b0, 1'b0, '0, '0);
      for (int j = 0; j < 256; j++) shadow[i][j] = init_val(8'(j));
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    @(negedge clk);

    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_dbg_lat3();
    test_round_robin();
    test_cpu_priority();
    test_reset_in_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
